// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    // Parity modes.
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Even parity: the extra bit makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_drain_if.sv
// Read port of a show-ahead byte FIFO: head byte, empty flag and pop request.
interface uart_tx_drain_if;
    import uart_pkg::*;

    logic                   fifo_rd;
    logic                   fifo_empty;
    logic [UART_DATA_W-1:0] fifo_data;

    // The drain side requests pops.
    modport master (output fifo_rd, input fifo_empty, input fifo_data);
    // The FIFO side supplies the head byte and empty flag.
    modport slave  (input fifo_rd, output fifo_empty, output fifo_data);
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: flags the last clock of every CLKS_PER_BIT-clock period.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_r;

    // Count 0..CLKS_PER_BIT-1 and wrap; restart holds the count at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (restart || (cnt_r == LAST_CNT)) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign bit_end = (cnt_r == LAST_CNT);

endmodule

// File: rtl/uart_tx_drain.sv
// Drains bytes from a show-ahead FIFO and sends each as a UART frame.
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    uart_tx_drain_if.master   fifo,
    output logic              tx,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frame_cnt
);

    uart_state_e            state_r, state_s;
    logic [UART_DATA_W-1:0] shift_r;
    logic                   parity_r;
    logic [2:0]             bit_cnt_r;
    logic                   stop_cnt_r;
    logic                   tx_r, tx_s;
    logic [15:0]            cnt_r;
    logic                   pop_s;
    logic                   bit_end_s;
    logic                   last_stop_s;
    logic                   frame_done_s;

    // The timer is held at zero in IDLE so the start bit gets a full period.
    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (state_r == ST_IDLE),
        .bit_end (bit_end_s)
    );

    assign pop_s        = rst_n & enable & ~fifo.fifo_empty & (state_r == ST_IDLE);
    assign last_stop_s  = (stop_cnt_r == 1'(STOP_BITS - 1));
    assign frame_done_s = (state_r == ST_STOP) & bit_end_s & last_stop_s;

    // Next state and next line level; tx is precomputed so it is registered.
    always_comb begin
        state_s = state_r;
        tx_s    = tx_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    state_s = ST_START;
                    tx_s    = 1'b0;
                end else begin
                    tx_s    = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_s = ST_DATA;
                    tx_s    = shift_r[0];
                end else begin
                    tx_s    = 1'b0;
                end
            end
            ST_DATA: begin
                if (bit_end_s && (bit_cnt_r == 3'd7)) begin
                    if (PARITY_EN == PARITY_EVEN) begin
                        state_s = ST_PARITY;
                        tx_s    = parity_r;
                    end else begin
                        state_s = ST_STOP;
                        tx_s    = 1'b1;
                    end
                end else if (bit_end_s) begin
                    tx_s = shift_r[1];
                end else begin
                    tx_s = shift_r[0];
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_s = ST_STOP;
                    tx_s    = 1'b1;
                end else begin
                    tx_s    = parity_r;
                end
            end
            ST_STOP: begin
                if (frame_done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_STOP;
                end
                tx_s = 1'b1;
            end
            default: begin
                state_s = ST_IDLE;
                tx_s    = 1'b1;
            end
        endcase
    end

    // State and line register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            tx_r    <= 1'b1;
        end else begin
            state_r <= state_s;
            tx_r    <= tx_s;
        end
    end

    // Shift register, parity capture, bit/stop counters and frame counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_r    <= '0;
            parity_r   <= 1'b0;
            bit_cnt_r  <= 3'd0;
            stop_cnt_r <= 1'b0;
            cnt_r      <= 16'd0;
        end else begin
            if (pop_s) begin
                shift_r    <= fifo.fifo_data;
                parity_r   <= even_parity(fifo.fifo_data);
                bit_cnt_r  <= 3'd0;
                stop_cnt_r <= 1'b0;
            end else if ((state_r == ST_DATA) && bit_end_s) begin
                shift_r    <= {1'b0, shift_r[UART_DATA_W-1:1]};
                bit_cnt_r  <= bit_cnt_r + 3'd1;
            end else if ((state_r == ST_STOP) && bit_end_s && !last_stop_s) begin
                stop_cnt_r <= 1'b1;
            end else begin
                shift_r    <= shift_r;
            end
            if (frame_done_s) begin
                cnt_r <= cnt_r + 16'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign fifo.fifo_rd = pop_s;
    assign tx           = tx_r;
    assign busy         = (state_r != ST_IDLE);
    assign frame_done   = frame_done_s;
    assign frame_cnt    = cnt_r;

endmodule

// File: doc/uart_tx_drain.md
# uart_tx_drain

Downstream consumer of the 16-entry byte FIFO: drains bytes through the FIFO's read port and transmits each one as an asynchronous serial frame (start, 8 data bits LSB-first, optional even parity, 1 or 2 stop bits) on a single line. It sits directly behind the FIFO's `rd`/`fifo_empty`/`data_out` interface. That interface has show-ahead semantics: `data_out` is the current head whenever the FIFO is not empty, and a pop takes effect at the clock edge where `rd` is high.

## Interface
- `CLKS_PER_BIT`, 16: clocks per serial bit; legal range 2..65535.
- `PARITY_EN`, 0: 0 = no parity bit; 1 = even parity bit after the data bits.
- `STOP_BITS`, 1: number of stop bits; legal values 1 or 2.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `enable`  in  1  permits starting new frames.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data`  in  8  FIFO head byte (`data_out`); valid when `fifo_empty`=0.
- `fifo_rd`  out  1  pop request to the FIFO.
- `tx`  out  1  serial line; idle high; registered.
- `busy`  out  1  high while a frame is in progress (any state except IDLE).
- `frame_done`  out  1  one-cycle pulse when a frame's last stop-bit period ends.
- `frame_cnt`  out  16  count of completed frames; wraps at 65535 -> 0.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `tx`=1.
  - `fifo_rd` = `rst_n` & `enable` & ~`fifo_empty` & (state==IDLE); this is combinational and is the only source of `fifo_rd`.
  - On an edge with `fifo_rd`=1: `fifo_data` is loaded into the shift register, parity = ^`fifo_data` is captured, the bit counter is cleared, and the state moves to START.
- START: `tx`=0 for `CLKS_PER_BIT` clocks, then DATA.
- DATA:
  - Shift register bit 0 drives `tx` for `CLKS_PER_BIT` clocks, then the register shifts right.
  - After 8 bits, go to PARITY if `PARITY_EN`=1, else STOP.
- PARITY: `tx` = captured even-parity bit for `CLKS_PER_BIT` clocks, then STOP.
- STOP:
  - `tx`=1 for `STOP_BITS`×`CLKS_PER_BIT` clocks, then IDLE.
  - On the final STOP clock, `frame_done`=1 and `frame_cnt` increments at the same edge.
- `enable` is sampled only in IDLE. Deasserting it mid-frame lets the current frame finish; no further pop occurs.
- A byte is popped exactly once per frame. `fifo_rd` is never asserted when `fifo_empty`=1 or outside IDLE.
- Reset with `rst_n`=0 at any edge, including mid-frame: state IDLE, `tx`=1, `busy`=0, `frame_done`=0, `frame_cnt`=0, shift register 0. `fifo_rd` is 0 throughout reset. An aborted frame is not counted and its byte is not re-read.

## Timing
- Pop edge at cycle T (IDLE, `fifo_rd`=1): `tx` falls to 0 and `busy` rises starting at cycle T+1.
- Bit k (k=0..7) occupies cycles T+1+(k+1)·`CLKS_PER_BIT` through T+(k+2)·`CLKS_PER_BIT`.
- Frame length F = (10 + `PARITY_EN` + `STOP_BITS` − 1)·`CLKS_PER_BIT` clocks of non-idle output.
- `frame_done` is high at cycle T+F and the state is IDLE at T+F+1.
- Back-to-back frames: if the FIFO is still non-empty, the next pop happens in that IDLE cycle. The inter-frame gap is exactly 1 extra clock of `tx`=1.
- Bit-period counter: width $clog2(`CLKS_PER_BIT`). It counts 0..`CLKS_PER_BIT`−1 and wraps with no off-by-one; each period is exactly `CLKS_PER_BIT` clocks.

## Structure
- Shared package `uart_pkg`: state enum type (IDLE/START/DATA/PARITY/STOP), constant `UART_DATA_W`=8, parity-mode constants.
- Sub-module `uart_bit_timer`:
  - Parameter `CLKS_PER_BIT`; inputs `clk`, `rst_n`, `restart`.
  - Output `bit_end`: high on the last clock of each bit period.
  - The FSM, shift register and `frame_cnt` stay in `uart_tx_drain`.

## Test plan
- FIFO holds 0xA5, `CLKS_PER_BIT`=4, no parity, 1 stop: one `fifo_rd` pulse. `tx` shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit 4 clocks (40 clocks total). `frame_done` fires once and `frame_cnt`=1.
- `PARITY_EN`=1, byte 0x07 (three ones): parity bit = 1. With byte 0x03: parity bit = 0.
- FIFO preloaded with 16 bytes 0x00..0x0F, `enable`=1:
  - 16 pops and 16 frames in order.
  - Gap between frames is exactly 1 clock.
  - FIFO ends empty and `fifo_rd` never coincides with `fifo_empty`=1.
- `enable` dropped during DATA of frame 1 with 3 bytes queued: frame 1 completes and no further pops happen. Re-asserting `enable` resumes with byte 2.
- `rst_n` pulled low mid-DATA for 1 clock:
  - At the next edge `tx`=1, `busy`=0, `frame_cnt`=0.
  - No `fifo_rd` during reset.
  - The next queued byte transmits cleanly afterwards.
- `STOP_BITS`=2, `CLKS_PER_BIT`=3: the stop period is 6 clocks and `frame_done` is high on its last clock only.
